// File: rtl/tft_compositor.sv
// tft_compositor: raster timing, panel power sequencer and N_RECT-layer
// solid-rectangle compositor driving registered 8-bit-per-channel RGB.
// Optional feature macro: TFT_PWR_SEQ_EN
//   defined   -> OFF -> VDD -> DISP -> RUN with PWR_DELAY clocks per step
//   undefined -> OFF -> RUN, all power controls rise together, no delay counter
module tft_compositor #(
    parameter int X_RES     = 480,
    parameter int Y_RES     = 272,
    parameter int X_BLANK   = 45,
    parameter int Y_BLANK   = 16,
    parameter int BPC       = 3,
    parameter int N_RECT    = 4,
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 9,
    parameter int PWR_DELAY = 16
) (
    input  logic                       tft_clk,
    input  logic                       rstb,
    input  logic [N_RECT-1:0]          rect_en,
    input  logic [N_RECT*X_BITS-1:0]   rect_x_min,
    input  logic [N_RECT*X_BITS-1:0]   rect_x_max,
    input  logic [N_RECT*Y_BITS-1:0]   rect_y_min,
    input  logic [N_RECT*Y_BITS-1:0]   rect_y_max,
    input  logic [N_RECT*3*BPC-1:0]    rect_color,
    input  logic [3*BPC-1:0]           bg_color,
    output logic [7:0]                 tft_red,
    output logic [7:0]                 tft_green,
    output logic [7:0]                 tft_blue,
    output logic                       tft_data_ena,
    output logic                       tft_vdd,
    output logic                       tft_display,
    output logic                       tft_backlight_ena,
    output logic [X_BITS-1:0]          x,
    output logic [Y_BITS-1:0]          y,
    output logic                       new_frame
);
    localparam int X_TOTAL = X_RES + X_BLANK;
    localparam int Y_TOTAL = Y_RES + Y_BLANK;
    localparam int CW      = 3 * BPC;
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_TOTAL - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_TOTAL - 1);
    localparam logic [X_BITS-1:0] X_ACT  = X_BITS'(X_RES);
    localparam logic [Y_BITS-1:0] Y_ACT  = Y_BITS'(Y_RES);

    typedef enum logic [1:0] {S_OFF, S_VDD, S_DISP, S_RUN} state_t;
    state_t state;

    // Shadow copies of the geometry/colour inputs, only updated between frames
    logic [N_RECT-1:0]        sh_en;
    logic [N_RECT*X_BITS-1:0] sh_xmin, sh_xmax;
    logic [N_RECT*Y_BITS-1:0] sh_ymin, sh_ymax;
    logic [N_RECT*CW-1:0]     sh_col;
    logic [CW-1:0]            sh_bg;

    logic          load_sh;
    logic          active;
    logic [CW-1:0] pix_c;

`ifdef TFT_PWR_SEQ_EN
    localparam int DW = $clog2(PWR_DELAY) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(PWR_DELAY - 1);
    logic [DW-1:0] dly_cnt;
    logic          dly_done;
    assign dly_done = (dly_cnt == D_LAST);
`endif

    // Power sequencer; power controls are set on the transition so they act
    // as registered, cumulative decodes of the state
    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            state             <= S_OFF;
            tft_vdd           <= 1'b0;
            tft_display       <= 1'b0;
            tft_backlight_ena <= 1'b0;
`ifdef TFT_PWR_SEQ_EN
            dly_cnt           <= '0;
`endif
        end else begin
            case (state)
                S_OFF: begin
`ifdef TFT_PWR_SEQ_EN
                    state   <= S_VDD;
                    tft_vdd <= 1'b1;
                    dly_cnt <= '0;
`else
                    state             <= S_RUN;
                    tft_vdd           <= 1'b1;
                    tft_display       <= 1'b1;
                    tft_backlight_ena <= 1'b1;
`endif
                end
`ifdef TFT_PWR_SEQ_EN
                S_VDD: begin
                    if (dly_done) begin
                        dly_cnt     <= '0;
                        state       <= S_DISP;
                        tft_display <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_DISP: begin
                    if (dly_done) begin
                        dly_cnt           <= '0;
                        state             <= S_RUN;
                        tft_backlight_ena <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign new_frame = (state == S_RUN) && (x == X_LAST) && (y == Y_LAST);
    // Leaving OFF always happens on the first clock with rstb high
    assign load_sh   = (state == S_OFF) || new_frame;
    assign active    = (state == S_RUN) && (x < X_ACT) && (y < Y_ACT);

    // Raster counters; held at zero outside RUN
    always_ff @(posedge tft_clk) begin
        if (!rstb || state != S_RUN) begin
            x <= '0;
            y <= '0;
        end else if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
            x <= x + 1'b1;
        end
    end

    // Shadow load at frame boundary and on power-up
    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            sh_en   <= '0;
            sh_xmin <= '0;
            sh_xmax <= '0;
            sh_ymin <= '0;
            sh_ymax <= '0;
            sh_col  <= '0;
            sh_bg   <= '0;
        end else if (load_sh) begin
            sh_en   <= rect_en;
            sh_xmin <= rect_x_min;
            sh_xmax <= rect_x_max;
            sh_ymin <= rect_y_min;
            sh_ymax <= rect_y_max;
            sh_col  <= rect_color;
            sh_bg   <= bg_color;
        end
    end

    // Priority mux: walk from highest index down so the lowest hit wins;
    // min>=max never satisfies both bounds, so degenerate layers drop out
    always_comb begin
        pix_c = sh_bg;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (sh_en[i] &&
                sh_xmin[i*X_BITS +: X_BITS] <= x && x < sh_xmax[i*X_BITS +: X_BITS] &&
                sh_ymin[i*Y_BITS +: Y_BITS] <= y && y < sh_ymax[i*Y_BITS +: Y_BITS])
                pix_c = sh_col[i*CW +: CW];
        end
    end

    // Left-justify a BPC-bit component into 8 bits, zero-filling the LSBs
    function automatic logic [7:0] expand(input logic [BPC-1:0] c);
        logic [7:0] e;
        e = '0;
        e[7 -: BPC] = c;
        return e;
    endfunction

    // Output register: one clock of pixel latency, data blanked with enable
    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            tft_data_ena <= 1'b0;
            tft_red      <= '0;
            tft_green    <= '0;
            tft_blue     <= '0;
        end else begin
            tft_data_ena <= active;
            tft_red      <= active ? expand(pix_c[CW-1 -: BPC])    : 8'h00;
            tft_green    <= active ? expand(pix_c[2*BPC-1 -: BPC]) : 8'h00;
            tft_blue     <= active ? expand(pix_c[BPC-1:0])        : 8'h00;
        end
    end

endmodule

// File: tb/tb_tft_compositor.sv
// Bench for tft_compositor: small raster, cycle-accurate reference model
// derived from edge counts since reset release, directed steps then random.
module tb_tft_compositor;
    localparam int XR = 40, YR = 30, XB = 5, YB = 4;
    localparam int BPC = 3, N = 4, XBI = 10, YBI = 9, PD = 16;
    localparam int XT = XR + XB, YT = YR + YB, FR = XT * YT, CW = 3 * BPC;
`ifdef TFT_PWR_SEQ_EN
    localparam int DISP_AT = 1 + PD, RUN_AT = 1 + 2 * PD;
`else
    localparam int DISP_AT = 1, RUN_AT = 1;
`endif

    logic                 tft_clk = 1'b0;
    logic                 rstb = 1'b0;
    logic [N-1:0]         rect_en = '0;
    logic [N*XBI-1:0]     rect_x_min = '0, rect_x_max = '0;
    logic [N*YBI-1:0]     rect_y_min = '0, rect_y_max = '0;
    logic [N*CW-1:0]      rect_color = '0;
    logic [CW-1:0]        bg_color = '0;
    logic [7:0]           tft_red, tft_green, tft_blue;
    logic                 tft_data_ena, tft_vdd, tft_display, tft_backlight_ena;
    logic [XBI-1:0]       x;
    logic [YBI-1:0]       y;
    logic                 new_frame;

    tft_compositor #(
        .X_RES(XR), .Y_RES(YR), .X_BLANK(XB), .Y_BLANK(YB), .BPC(BPC),
        .N_RECT(N), .X_BITS(XBI), .Y_BITS(YBI), .PWR_DELAY(PD)
    ) dut (
        .tft_clk(tft_clk), .rstb(rstb), .rect_en(rect_en),
        .rect_x_min(rect_x_min), .rect_x_max(rect_x_max),
        .rect_y_min(rect_y_min), .rect_y_max(rect_y_max),
        .rect_color(rect_color), .bg_color(bg_color),
        .tft_red(tft_red), .tft_green(tft_green), .tft_blue(tft_blue),
        .tft_data_ena(tft_data_ena), .tft_vdd(tft_vdd), .tft_display(tft_display),
        .tft_backlight_ena(tft_backlight_ena), .x(x), .y(y), .new_frame(new_frame)
    );

    always #5 tft_clk = ~tft_clk;

    int checks = 0;
    int errors = 0;
    int k = 0;   // clock edges seen with rstb high since the last reset edge

    // model's copy of what the frame being drawn was built from
    logic [N-1:0]     s_en = '0;
    logic [N*XBI-1:0] s_x0 = '0, s_x1 = '0;
    logic [N*YBI-1:0] s_y0 = '0, s_y1 = '0;
    logic [N*CW-1:0]  s_col = '0;
    logic [CW-1:0]    s_bg = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // raster position implied by an edge count
    task automatic pos(input int kk, output int px, output int py);
        int t;
        if (kk >= RUN_AT) begin
            t  = kk - RUN_AT;
            px = t % XT;
            py = (t / XT) % YT;
        end else begin
            px = 0;
            py = 0;
        end
    endtask

    // first enabled rectangle containing the pixel, else background
    function automatic logic [23:0] ref_pixel(input int px, input int py);
        logic [CW-1:0] c;
        logic [7:0] r, g, b;
        int x0, x1, y0, y1;
        c = s_bg;
        for (int i = 0; i < N; i++) begin
            x0 = int'(s_x0[i*XBI +: XBI]);
            x1 = int'(s_x1[i*XBI +: XBI]);
            y0 = int'(s_y0[i*YBI +: YBI]);
            y1 = int'(s_y1[i*YBI +: YBI]);
            if (s_en[i] && px >= x0 && px < x1 && py >= y0 && py < y1) begin
                c = s_col[i*CW +: CW];
                break;
            end
        end
        r = 8'(c[CW-1 -: BPC]) << (8 - BPC);
        g = 8'(c[2*BPC-1 -: BPC]) << (8 - BPC);
        b = 8'(c[BPC-1:0]) << (8 - BPC);
        return {r, g, b};
    endfunction

    // advance one clock and check every output against the model
    task automatic tick();
        int px, py, nx, ny;
        logic exp_de, exp_nf;
        logic [23:0] exp_rgb;
        pos(k, px, py);
        exp_de  = rstb && (k >= RUN_AT) && px < XR && py < YR;
        exp_rgb = exp_de ? ref_pixel(px, py) : 24'h0;
        if (rstb && (k == 0 || (k >= RUN_AT && (k - RUN_AT) % FR == FR - 1))) begin
            s_en = rect_en; s_x0 = rect_x_min; s_x1 = rect_x_max;
            s_y0 = rect_y_min; s_y1 = rect_y_max; s_col = rect_color; s_bg = bg_color;
        end
        k = rstb ? k + 1 : 0;
        @(posedge tft_clk);
        #1;
        pos(k, nx, ny);
        exp_nf = (k >= RUN_AT) && ((k - RUN_AT) % FR == FR - 1);
        chk("x", 32'(x), 32'(nx));
        chk("y", 32'(y), 32'(ny));
        chk("vdd", 32'(tft_vdd), 32'(k >= 1));
        chk("display", 32'(tft_display), 32'(k >= DISP_AT));
        chk("backlight", 32'(tft_backlight_ena), 32'(k >= RUN_AT));
        chk("new_frame", 32'(new_frame), 32'(exp_nf));
        chk("data_ena", 32'(tft_data_ena), 32'(exp_de));
        chk("rgb", 32'({tft_red, tft_green, tft_blue}), 32'(exp_rgb));
    endtask

    // tick until the DUT is presenting (tx,ty) before the next edge
    task automatic run_to(input int tx, input int ty);
        int px, py;
        bit found;
        found = 0;
        for (int n = 0; n < FR + RUN_AT + 4; n++) begin
            pos(k, px, py);
            if (k >= RUN_AT && px == tx && py == ty) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        assert (found)
        else begin
            errors++;
            $error("FAIL run_to_timeout observed=%0d,%0d expected=%0d,%0d", x, y, tx, ty);
        end
    endtask

    task automatic set_layer(input int i, input logic en, input int x0, input int x1,
                             input int y0, input int y1, input logic [CW-1:0] col);
        rect_en[i] = en;
        rect_x_min[i*XBI +: XBI] = XBI'(x0);
        rect_x_max[i*XBI +: XBI] = XBI'(x1);
        rect_y_min[i*YBI +: YBI] = YBI'(y0);
        rect_y_max[i*YBI +: YBI] = YBI'(y1);
        rect_color[i*CW +: CW] = col;
    endtask

    task automatic priority_cfg();
        set_layer(0, 1'b1, 10, 20, 10, 20, 9'o700);
        set_layer(1, 1'b1, 15, 30, 15, 30, 9'o007);
        set_layer(2, 1'b0, 0, 0, 0, 0, 9'o000);
        set_layer(3, 1'b0, 0, 0, 0, 0, 9'o000);
        bg_color = 9'o730;
    endtask

    initial begin
        int v_at, d_at, b_at, x1_at, per, de_cnt, bad, n;

        // reset state
        priority_cfg();
        rstb = 1'b0;
        repeat (3) tick();
        chk("reset_x", 32'(x), 32'd0);
        chk("reset_vdd", 32'(tft_vdd), 32'd0);

        // power-up ramp
        v_at = -1; d_at = -1; b_at = -1; x1_at = -1;
        rstb = 1'b1;
        for (int i = 0; i < RUN_AT + 6; i++) begin
            tick();
            if (tft_vdd === 1'b1 && v_at < 0) v_at = k;
            if (tft_display === 1'b1 && d_at < 0) d_at = k;
            if (tft_backlight_ena === 1'b1 && b_at < 0) b_at = k;
            if (x == 1 && x1_at < 0) x1_at = k;
        end
        chk("vdd_rise", 32'(v_at), 32'd1);
        chk("display_rise", 32'(d_at), 32'(DISP_AT));
        chk("backlight_rise", 32'(b_at), 32'(RUN_AT));
        chk("x_first_1", 32'(x1_at), 32'(RUN_AT + 1));

        // priority overlap
        run_to(15, 15); tick();
        chk("p15_15", 32'({tft_red, tft_green, tft_blue}), 32'h00E00000);
        run_to(25, 25); tick();
        chk("p25_25", 32'({tft_red, tft_green, tft_blue}), 32'h000000E0);
        run_to(20, 12); tick();
        chk("p20_12", 32'({tft_red, tft_green, tft_blue}), 32'h00E06000);

        // frame period and active-pixel count
        n = 0;
        while (new_frame !== 1'b1 && n < 2 * FR) begin tick(); n++; end
        per = 0; de_cnt = 0;
        do begin
            tick();
            per++;
            if (tft_data_ena === 1'b1) de_cnt++;
        end while (new_frame !== 1'b1 && per < 2 * FR);
        chk("frame_period", 32'(per), 32'(FR));
        chk("de_per_frame", 32'(de_cnt), 32'(XR * YR));

        // shadow latching: mid-frame change is invisible until next frame
        run_to(0, 5);
        rect_x_min[0 +: XBI] = XBI'(16);
        run_to(12, 12); tick();
        chk("shadow_hold", 32'({tft_red, tft_green, tft_blue}), 32'h00E00000);
        run_to(12, 12); tick();
        chk("shadow_new", 32'({tft_red, tft_green, tft_blue}), 32'h00E06000);

        // degenerate layer: background everywhere
        set_layer(0, 1'b1, 20, 20, 0, YR, 9'o777);
        set_layer(1, 1'b0, 0, 0, 0, 0, 9'o000);
        bg_color = 9'o152;
        n = 0;
        while (new_frame !== 1'b1 && n < 2 * FR) begin tick(); n++; end
        bad = 0; de_cnt = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (tft_data_ena === 1'b1) begin
                de_cnt++;
                if ({tft_red, tft_green, tft_blue} !== 24'h20A040) bad++;
            end
        end
        chk("degenerate_non_bg", 32'(bad), 32'd0);
        chk("degenerate_de", 32'(de_cnt), 32'(XR * YR));

        // mid-frame reset and restart
        priority_cfg();
        run_to(20, 15);
        rstb = 1'b0;
        tick();
        chk("mreset_x", 32'(x), 32'd0);
        chk("mreset_y", 32'(y), 32'd0);
        chk("mreset_vdd", 32'(tft_vdd), 32'd0);
        chk("mreset_de", 32'(tft_data_ena), 32'd0);
        rstb = 1'b1;
        repeat (RUN_AT + 5) tick();
        chk("restart_bl", 32'(tft_backlight_ena), 32'd1);
        chk("restart_x", 32'(x), 32'd5);

        // random geometry/colour changes at random moments
        for (int i = 0; i < 3 * FR; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                set_layer(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, XT)), int'($urandom_range(0, XT)),
                          int'($urandom_range(0, YT)), int'($urandom_range(0, YT)),
                          CW'($urandom));
                if ($urandom_range(0, 3) == 0) bg_color = CW'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
